// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  localparam int DEF_DATO_WIDTH  = 8;
  localparam int DEF_FIFO_LENGTH = 5;
  localparam int DEF_AF_LEVEL    = 4;
  localparam int DEF_AE_LEVEL    = 1;

  // Ceiling log2, never less than 1 so single-entry ranges still get a bit.
  function automatic int fifo_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Occupancy width: must hold 0..depth inclusive.
  function automatic int fifo_cw(input int depth);
    return fifo_clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_sync_param_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module fifo_sync_param_mem
  import fifo_pkg::*;
#(
  parameter int dato_width  = DEF_DATO_WIDTH,
  parameter int fifo_length = DEF_FIFO_LENGTH
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [fifo_clog2(fifo_length)-1:0]  waddr,
  input  logic [dato_width-1:0]               wdata,
  input  logic [fifo_clog2(fifo_length)-1:0]  raddr,
  output logic [dato_width-1:0]               rdata
);

  logic [dato_width-1:0] mem [fifo_length];

  // Contents are intentionally not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky
// overflow/underflow, synchronous flush and optional first-word-fall-through.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int dato_width  = DEF_DATO_WIDTH,
  parameter int fifo_length = DEF_FIFO_LENGTH,
  parameter int af_level    = DEF_AF_LEVEL,
  parameter int ae_level    = DEF_AE_LEVEL,
  parameter int fwft        = FIFO_STD
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              wr,
  input  logic [dato_width-1:0]             datin,
  input  logic                              rd,
  output logic [dato_width-1:0]             datout,
  output logic                              full,
  output logic                              empy,
  output logic                              dato,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [fifo_cw(fifo_length)-1:0]   count,
  output logic                              ovf,
  output logic                              udf
);

  localparam int CW = fifo_cw(fifo_length);
  localparam int PW = fifo_clog2(fifo_length);
  localparam logic [CW-1:0] LEN  = CW'(fifo_length);
  localparam logic [CW-1:0] AF   = CW'(af_level);
  localparam logic [CW-1:0] AE   = CW'(ae_level);
  localparam logic [PW-1:0] LAST = PW'(fifo_length - 1);

  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count_q;
  logic [dato_width-1:0] rd_data, dout_q;
  logic                  ovf_q, udf_q;
  logic                  rd_ok, wr_ok;

  // Non-power-of-two depth: wrap on explicit compare instead of modulo.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empy         = (count_q == '0);
  assign full         = (count_q == LEN);
  assign dato         = ~empy;
  assign almost_full  = (count_q >= AF);
  assign almost_empty = (count_q <= AE);
  assign count        = count_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;

  // Handshake: a read is accepted when rd=1 and the FIFO holds data; a write
  // is accepted when wr=1 and there is room, or when a read frees a slot in
  // the same cycle. flush=1 cancels both acceptances for that cycle.
  assign rd_ok = rd & ~empy;
  assign wr_ok = wr & (~full | rd_ok);

  fifo_sync_param_mem #(
    .dato_width  (dato_width),
    .fifo_length (fifo_length)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok & ~flush),
    .waddr (wptr),
    .wdata (datin),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dout_q  <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (wr_ok) wptr <= ptr_inc(wptr);
      if (rd_ok) rptr <= ptr_inc(rptr);
      if (wr_ok && !rd_ok)      count_q <= count_q + CW'(1);
      else if (rd_ok && !wr_ok) count_q <= count_q - CW'(1);
      if (wr && !wr_ok) ovf_q <= 1'b1;
      if (rd && !rd_ok) udf_q <= 1'b1;
      // Head word is read before any same-edge write lands, so full+rd+wr is safe.
      if (rd_ok && fwft == FIFO_STD) dout_q <= rd_data;
    end
  end

  assign datout = (fwft == FIFO_FWFT) ? rd_data : dout_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: one registered-read and one FWFT instance share stimulus
// and are compared against a queue-based model of the FIFO rules.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int W  = 8;
  localparam int L  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int CW = fifo_cw(L);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [W-1:0]  datin = '0;

  logic [W-1:0]  datout_s, datout_f;
  logic          full_s, empy_s, dato_s, af_s, ae_s, ovf_s, udf_s;
  logic          full_f, empy_f, dato_f, af_f, ae_f, ovf_f, udf_f;
  logic [CW-1:0] count_s, count_f;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] ref_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ref_dout;
  bit           ref_ovf, ref_udf, rd_pending, r_ok, w_ok;

  fifo_sync_param #(.dato_width(W), .fifo_length(L), .af_level(AF), .ae_level(AE),
                    .fwft(FIFO_STD)) dut_std (
    .clk(clk), .rst(rst), .flush(flush), .wr(wr), .datin(datin), .rd(rd),
    .datout(datout_s), .full(full_s), .empy(empy_s), .dato(dato_s),
    .almost_full(af_s), .almost_empty(ae_s), .count(count_s), .ovf(ovf_s), .udf(udf_s)
  );

  fifo_sync_param #(.dato_width(W), .fifo_length(L), .af_level(AF), .ae_level(AE),
                    .fwft(FIFO_FWFT)) dut_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr(wr), .datin(datin), .rd(rd),
    .datout(datout_f), .full(full_f), .empy(empy_f), .dato(dato_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(count_f), .ovf(ovf_f), .udf(udf_f)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = ref_q.size();
    check("count_std",  32'(count_s), 32'(sz));
    check("full_std",   32'(full_s),  32'(sz == L));
    check("empy_std",   32'(empy_s),  32'(sz == 0));
    check("dato_std",   32'(dato_s),  32'(sz != 0));
    check("af_std",     32'(af_s),    32'(sz >= AF));
    check("ae_std",     32'(ae_s),    32'(sz <= AE));
    check("ovf_std",    32'(ovf_s),   32'(ref_ovf));
    check("udf_std",    32'(udf_s),   32'(ref_udf));
    check("count_fwft", 32'(count_f), 32'(sz));
    check("full_fwft",  32'(full_f),  32'(sz == L));
    check("empy_fwft",  32'(empy_f),  32'(sz == 0));
    check("dato_fwft",  32'(dato_f),  32'(sz != 0));
    check("af_fwft",    32'(af_f),    32'(sz >= AF));
    check("ae_fwft",    32'(ae_f),    32'(sz <= AE));
    check("ovf_fwft",   32'(ovf_f),   32'(ref_ovf));
    check("udf_fwft",   32'(udf_f),   32'(ref_udf));
  endtask

  // Reference model: a plain queue updated by the accept rules at each edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q.delete();
      exp_q.delete();
      ref_ovf    = 1'b0;
      ref_udf    = 1'b0;
      ref_dout   = '0;
      rd_pending = 1'b0;
    end else if (flush) begin
      ref_q.delete();
      ref_ovf  = 1'b0;
      ref_udf  = 1'b0;
      ref_dout = '0;
    end else begin
      r_ok = rd && (ref_q.size() > 0);
      w_ok = wr && ((ref_q.size() < L) || r_ok);
      if (r_ok) begin
        ref_dout = ref_q.pop_front();
        exp_q.push_back(ref_dout);
        rd_pending = 1'b1;
      end
      if (w_ok) ref_q.push_back(datin);
      if (wr && !w_ok) ref_ovf = 1'b1;
      if (rd && !r_ok) ref_udf = 1'b1;
    end
  end

  // Monitor: sample on the falling edge, pop the scoreboard when a read landed.
  always @(negedge clk) begin
    if (rd_pending) begin
      if (exp_q.size() > 0) check("datout_std", 32'(datout_s), 32'(exp_q.pop_front()));
      else check("exp_q_nonempty", 32'(0), 32'(1));
      rd_pending = 1'b0;
    end
    check("datout_hold", 32'(datout_s), 32'(ref_dout));
    if (ref_q.size() > 0) check("datout_fwft", 32'(datout_f), 32'(ref_q[0]));
    check_state();
  end

  // Driver
  task automatic cycle(input bit w, input bit r, input logic [W-1:0] d, input bit f);
    @(negedge clk);
    #1;
    wr = w; rd = r; datin = d; flush = f;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_state();
    check("reset_datout", 32'(datout_s), 32'(0));
    rst = 1'b1;

    for (int i = 1; i <= 5; i++) cycle(1, 0, W'(8'h11 * i), 0);
    cycle(1, 0, 8'hAA, 0);
    cycle(1, 1, 8'hBB, 0);
    repeat (5) cycle(0, 1, 8'h00, 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);

    cycle(1, 0, 8'h5A, 0);
    cycle(0, 0, 8'h00, 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);

    // Wrap-around at steady occupancy of two.
    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h01, 0);
    cycle(1, 0, 8'h02, 0);
    for (int i = 0; i < 12; i++) cycle(1, 1, W'($urandom_range(0, 255)), 0);
    repeat (2) cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);

    // Flush with count=3 and ovf set, while rd and wr are also requested.
    for (int i = 0; i < 6; i++) cycle(1, 0, W'($urandom_range(0, 255)), 0);
    repeat (2) cycle(0, 1, 8'h00, 0);
    cycle(1, 1, 8'hC3, 1);
    cycle(0, 0, 8'h00, 0);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
            W'($urandom_range(0, 255)), $urandom_range(0, 39) == 0);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 3; i++) cycle(1, 0, W'($urandom_range(0, 255)), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_state();
    check("async_reset_datout", 32'(datout_s), 32'(0));
    check("async_reset_count", 32'(count_s), 32'(0));
    @(negedge clk);
    #1;
    rst = 1'b1; wr = 1'b0; rd = 1'b0;

    for (int i = 0; i < 40; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 1), W'($urandom_range(0, 255)), 0);
    repeat (3) cycle(0, 0, 8'h00, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
